// File: rtl/drp_pkg.sv
// Shared DRP definitions: FSM state encoding plus default widths and timeout.
package drp_pkg;
    localparam int unsigned C_DRP_ADDR_WIDTH = 12;
    localparam int unsigned C_DRP_DATA_WIDTH = 16;
    localparam int unsigned C_DRP_TIMEOUT    = 1024;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        WR_REQ  = 3'd3,
        WR_WAIT = 3'd4,
        DONE    = 3'd5
    } drp_state_t;
endpackage

// File: rtl/drp_timeout.sv
// Clearable up-counter; o_expired flags the last cycle of the wait window.
module drp_timeout #(
    parameter int unsigned C_TIMEOUT = 1024
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expired
);
    localparam int unsigned CW = (C_TIMEOUT > 2) ? $clog2(C_TIMEOUT) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(C_TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_expired = (r_cnt == C_LAST);
endmodule

// File: rtl/drp_rmw_master.sv
// DRP initiator: single reads, full writes and masked read-modify-write with a
// bounded wait for M_DRPRDY_I. All outputs are registered.
module drp_rmw_master
    import drp_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH = C_DRP_ADDR_WIDTH,
    parameter int unsigned C_DATA_WIDTH = C_DRP_DATA_WIDTH,
    parameter int unsigned C_TIMEOUT    = C_DRP_TIMEOUT
) (
    input  logic                    DRPCLK_I,
    input  logic                    DRPRSTN_I,
    input  logic                    CMD_VALID_I,
    output logic                    CMD_READY_O,
    input  logic                    CMD_WR_I,
    input  logic [C_ADDR_WIDTH-1:0] CMD_ADDR_I,
    input  logic [C_DATA_WIDTH-1:0] CMD_MASK_I,
    input  logic [C_DATA_WIDTH-1:0] CMD_DATA_I,
    output logic                    RSP_VALID_O,
    output logic [C_DATA_WIDTH-1:0] RSP_DATA_O,
    output logic                    RSP_TIMEOUT_O,
    output logic                    BUSY_O,
    output logic [C_ADDR_WIDTH-1:0] M_DRPADDR_O,
    output logic [C_DATA_WIDTH-1:0] M_DRPDI_O,
    input  logic [C_DATA_WIDTH-1:0] M_DRPDO_I,
    output logic                    M_DRPEN_O,
    output logic                    M_DRPWE_O,
    input  logic                    M_DRPRDY_I
);
    drp_state_t              r_state;
    logic                    r_wr;
    logic [C_DATA_WIDTH-1:0] r_mask;
    logic [C_DATA_WIDTH-1:0] r_data;
    logic                    r_cmd_ready;
    logic                    r_busy;
    logic                    r_rsp_valid;
    logic [C_DATA_WIDTH-1:0] r_rsp_data;
    logic                    r_rsp_timeout;
    logic [C_ADDR_WIDTH-1:0] r_drp_addr;
    logic [C_DATA_WIDTH-1:0] r_drp_di;
    logic                    r_drp_en;
    logic                    r_drp_we;

    logic w_waiting;
    logic w_expired;

    // Counter is held clear outside the wait states, so it restarts per access.
    assign w_waiting = (r_state == RD_WAIT) || (r_state == WR_WAIT);

    drp_timeout #(
        .C_TIMEOUT (C_TIMEOUT)
    ) u_timeout (
        .i_clk     (DRPCLK_I),
        .i_rst_n   (DRPRSTN_I),
        .i_clr     (!w_waiting),
        .i_inc     (w_waiting && !M_DRPRDY_I),
        .o_expired (w_expired)
    );

    always_ff @(posedge DRPCLK_I or negedge DRPRSTN_I) begin
        if (!DRPRSTN_I) begin
            r_state       <= IDLE;
            r_wr          <= 1'b0;
            r_mask        <= '0;
            r_data        <= '0;
            r_cmd_ready   <= 1'b1;
            r_busy        <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
            r_drp_addr    <= '0;
            r_drp_di      <= '0;
            r_drp_en      <= 1'b0;
            r_drp_we      <= 1'b0;
        end else begin
            r_drp_en      <= 1'b0;
            r_drp_we      <= 1'b0;
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (CMD_VALID_I) begin
                        r_wr        <= CMD_WR_I;
                        r_mask      <= CMD_MASK_I;
                        r_data      <= CMD_DATA_I;
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_drp_addr  <= CMD_ADDR_I;
                        r_drp_en    <= 1'b1;
                        if (CMD_WR_I && (&CMD_MASK_I)) begin
                            r_drp_we <= 1'b1;
                            r_drp_di <= CMD_DATA_I;
                            r_state  <= WR_REQ;
                        end else begin
                            r_state  <= RD_REQ;
                        end
                    end
                end
                RD_REQ: r_state <= RD_WAIT;
                RD_WAIT: begin
                    if (M_DRPRDY_I) begin
                        if (r_wr) begin
                            r_drp_di <= (M_DRPDO_I & ~r_mask) | (r_data & r_mask);
                            r_drp_en <= 1'b1;
                            r_drp_we <= 1'b1;
                            r_state  <= WR_REQ;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= M_DRPDO_I;
                            r_state     <= DONE;
                        end
                    end else if (w_expired) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_data    <= '0;
                        r_state       <= DONE;
                    end
                end
                WR_REQ: r_state <= WR_WAIT;
                WR_WAIT: begin
                    if (M_DRPRDY_I) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_drp_di;
                        r_state     <= DONE;
                    end else if (w_expired) begin
                        r_rsp_valid   <= 1'b1;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_data    <= '0;
                        r_state       <= DONE;
                    end
                end
                DONE: begin
                    r_cmd_ready <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign CMD_READY_O   = r_cmd_ready;
    assign BUSY_O        = r_busy;
    assign RSP_VALID_O   = r_rsp_valid;
    assign RSP_DATA_O    = r_rsp_data;
    assign RSP_TIMEOUT_O = r_rsp_timeout;
    assign M_DRPADDR_O   = r_drp_addr;
    assign M_DRPDI_O     = r_drp_di;
    assign M_DRPEN_O     = r_drp_en;
    assign M_DRPWE_O     = r_drp_we;
endmodule

// File: tb/tb_drp_rmw_master.sv
// Directed bench for drp_rmw_master: a transaction-level timeline model predicts
// every DRP pulse and response; a negedge process compares against it each cycle.
module tb_drp_rmw_master;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [11:0] cmd_addr = '0;
    logic [15:0] cmd_mask = '0;
    logic [15:0] cmd_data = '0;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_timeout;
    logic        busy;
    logic [11:0] drp_addr;
    logic [15:0] drp_di;
    logic [15:0] drp_do = '0;
    logic        drp_en;
    logic        drp_we;
    logic        drp_rdy = 1'b0;

    drp_rmw_master #(
        .C_ADDR_WIDTH (12),
        .C_DATA_WIDTH (16),
        .C_TIMEOUT    (TMO)
    ) dut (
        .DRPCLK_I      (clk),
        .DRPRSTN_I     (rst_n),
        .CMD_VALID_I   (cmd_valid),
        .CMD_READY_O   (cmd_ready),
        .CMD_WR_I      (cmd_wr),
        .CMD_ADDR_I    (cmd_addr),
        .CMD_MASK_I    (cmd_mask),
        .CMD_DATA_I    (cmd_data),
        .RSP_VALID_O   (rsp_valid),
        .RSP_DATA_O    (rsp_data),
        .RSP_TIMEOUT_O (rsp_timeout),
        .BUSY_O        (busy),
        .M_DRPADDR_O   (drp_addr),
        .M_DRPDI_O     (drp_di),
        .M_DRPDO_I     (drp_do),
        .M_DRPEN_O     (drp_en),
        .M_DRPWE_O     (drp_we),
        .M_DRPRDY_I    (drp_rdy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int tag; bit we; logic [11:0] addr; logic [15:0] di; } en_ev_t;
    typedef struct { int tag; logic [15:0] data; bit to; } rsp_ev_t;
    en_ev_t  en_q[$];
    rsp_ev_t rsp_q[$];
    int busy_lo = 1, busy_hi = 0;
    bit chk_en = 1'b0;

    int checks = 0, failures = 0;
    int en_count = 0, we_count = 0, rsp_count = 0;
    int last_rsp_cyc = 0, last_en_cyc = 0, last_p0 = 0;
    logic [15:0] last_rsp_data = '0;
    logic        last_rsp_to = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=0x%0h required=0x%0h", name, cyc, act, req);
        end
    endtask

    initial begin : compare
        bit exp_busy, exp_en, exp_rsp;
        forever begin
            @(negedge clk);
            if (drp_en) begin en_count++; last_en_cyc = cyc; end
            if (drp_en && drp_we) we_count++;
            if (rsp_valid) begin
                rsp_count++;
                last_rsp_cyc  = cyc;
                last_rsp_data = rsp_data;
                last_rsp_to   = rsp_timeout;
            end
            if (chk_en) begin
                exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
                check("cmd_ready", cmd_ready, !exp_busy);
                check("busy", busy, exp_busy);
                exp_en = (en_q.size() > 0) && (en_q[0].tag == cyc);
                check("drp_en", drp_en, exp_en);
                if (exp_en) begin
                    check("drp_we", drp_we, en_q[0].we);
                    check("drp_addr", drp_addr, en_q[0].addr);
                    if (en_q[0].we) check("drp_di", drp_di, en_q[0].di);
                    void'(en_q.pop_front());
                end else begin
                    check("drp_we_idle", drp_we, 1'b0);
                end
                exp_rsp = (rsp_q.size() > 0) && (rsp_q[0].tag == cyc);
                check("rsp_valid", rsp_valid, exp_rsp);
                if (exp_rsp) begin
                    check("rsp_data", rsp_data, rsp_q[0].data);
                    check("rsp_timeout", rsp_timeout, rsp_q[0].to);
                    void'(rsp_q.pop_front());
                end
            end
        end
    end

    // Called at a negedge while the DUT is (or is about to be) idle. k1/k2 are the
    // ready delays after each EN; 0 means the slave never answers. Returns at the
    // negedge of the cycle right after the response.
    task automatic issue(input bit wr, input logic [11:0] addr, input logic [15:0] mask,
                         input logic [15:0] data, input int k1, input int k2,
                         input logic [15:0] rd_val, input bit hold);
        int p0, rtag, wtag;
        rsp_ev_t r;
        logic [15:0] newv;
        p0 = cyc + 1;
        rtag = -1;
        wtag = -1;
        if (wr && mask == 16'hFFFF) begin
            en_q.push_back('{p0, 1'b1, addr, data});
            if (k1 > 0) begin wtag = p0 + k1; r = '{p0 + 1 + k1, data, 1'b0}; end
            else r = '{p0 + TMO + 1, 16'h0, 1'b1};
        end else begin
            en_q.push_back('{p0, 1'b0, addr, 16'h0});
            if (k1 == 0) begin
                r = '{p0 + TMO + 1, 16'h0, 1'b1};
            end else begin
                rtag = p0 + k1;
                if (!wr) begin
                    r = '{p0 + 1 + k1, rd_val, 1'b0};
                end else begin
                    newv = (rd_val & ~mask) | (data & mask);
                    en_q.push_back('{p0 + 1 + k1, 1'b1, addr, newv});
                    if (k2 > 0) begin wtag = p0 + 1 + k1 + k2; r = '{wtag + 1, newv, 1'b0}; end
                    else r = '{p0 + 2 + k1 + TMO, 16'h0, 1'b1};
                end
            end
        end
        rsp_q.push_back(r);
        busy_lo = p0;
        busy_hi = r.tag;
        last_p0 = p0;
        en_count = 0;
        we_count = 0;
        cmd_valid = 1'b1;
        cmd_wr = wr;
        cmd_addr = addr;
        cmd_mask = mask;
        cmd_data = data;
        while (cyc <= r.tag) begin
            drp_rdy = (cyc == rtag) || (cyc == wtag);
            drp_do  = (cyc == rtag) ? rd_val : 16'hDEAD;
            if (cyc == p0 && !hold) cmd_valid = 1'b0;
            @(negedge clk);
        end
        drp_rdy = 1'b0;
        drp_do = 16'hDEAD;
    endtask

    task automatic idle(input int n, input bit rdy);
        repeat (n) begin
            drp_rdy = rdy;
            @(negedge clk);
        end
        drp_rdy = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1);
    end

    initial begin : stim
        int r1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);
        check("reset_ready", cmd_ready, 1'b1);
        check("reset_en", drp_en, 1'b0);
        check("reset_rsp", rsp_valid, 1'b0);
        check("reset_addr", drp_addr, 12'h000);
        idle(1, 1'b0);

        // plain read, k=3
        issue(1'b0, 12'h012, 16'h0000, 16'h0000, 3, 0, 16'hBEEF, 1'b0);
        check("rd_latency", last_rsp_cyc - last_p0 + 1, 5);
        check("rd_data", last_rsp_data, 16'hBEEF);
        check("rd_to", last_rsp_to, 1'b0);
        check("rd_en_cnt", en_count, 1);
        check("rd_we_cnt", we_count, 0);
        idle(2, 1'b0);

        // masked RMW
        issue(1'b1, 12'h045, 16'h00F0, 16'h1234, 2, 1, 16'hAAAA, 1'b0);
        check("rmw_data", last_rsp_data, 16'hAA3A);
        check("rmw_en_cnt", en_count, 2);
        check("rmw_we_cnt", we_count, 1);
        idle(2, 1'b0);

        // full write, no read
        issue(1'b1, 12'h321, 16'hFFFF, 16'h5A5A, 2, 0, 16'h0000, 1'b0);
        check("fw_data", last_rsp_data, 16'h5A5A);
        check("fw_en_cnt", en_count, 1);
        check("fw_we_cnt", we_count, 1);
        idle(1, 1'b0);

        // ready right after EN
        issue(1'b0, 12'h7FF, 16'h0000, 16'h0000, 1, 0, 16'h0001, 1'b0);
        check("k1_latency", last_rsp_cyc - last_p0 + 1, 3);
        idle(1, 1'b0);

        // zero mask writes back the old value
        issue(1'b1, 12'h0C3, 16'h0000, 16'hFFFF, 1, 4, 16'h1357, 1'b0);
        check("mask0_data", last_rsp_data, 16'h1357);
        check("mask0_en_cnt", en_count, 2);
        idle(1, 1'b0);

        // ready in the very last cycle of the window
        issue(1'b0, 12'h0AA, 16'h0000, 16'h0000, TMO, 0, 16'hC0DE, 1'b0);
        check("lastcyc_to", last_rsp_to, 1'b0);
        check("lastcyc_data", last_rsp_data, 16'hC0DE);
        idle(1, 1'b0);

        // read timeout, stray ready afterwards, then a normal read
        issue(1'b0, 12'h100, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1'b0);
        check("tmo_to", last_rsp_to, 1'b1);
        check("tmo_data", last_rsp_data, 16'h0000);
        check("tmo_delay", last_rsp_cyc - last_p0, 17);
        idle(3, 1'b1);
        issue(1'b0, 12'h101, 16'h0000, 16'h0000, 2, 0, 16'h4242, 1'b0);
        check("post_tmo_data", last_rsp_data, 16'h4242);
        idle(1, 1'b0);

        // RMW whose read times out never writes
        issue(1'b1, 12'h200, 16'h0F0F, 16'h1111, 0, 0, 16'h0000, 1'b0);
        check("rmw_rdtmo_en_cnt", en_count, 1);
        check("rmw_rdtmo_to", last_rsp_to, 1'b1);
        idle(1, 1'b0);

        // RMW whose write times out
        issue(1'b1, 12'h201, 16'hFF00, 16'hABCD, 2, 0, 16'h1234, 1'b0);
        check("rmw_wrtmo_to", last_rsp_to, 1'b1);
        check("rmw_wrtmo_en_cnt", en_count, 2);
        idle(1, 1'b0);

        // back-to-back with valid held
        issue(1'b0, 12'h010, 16'h0000, 16'h0000, 2, 0, 16'h0A0A, 1'b1);
        r1 = last_rsp_cyc;
        issue(1'b0, 12'h011, 16'h0000, 16'h0000, 1, 0, 16'h0B0B, 1'b1);
        check("b2b_gap", last_en_cyc - r1, 2);
        check("b2b_data", last_rsp_data, 16'h0B0B);
        issue(1'b1, 12'h012, 16'hFFFF, 16'h7777, 3, 0, 16'h0000, 1'b0);
        check("b2b_fw_data", last_rsp_data, 16'h7777);
        idle(2, 1'b0);

        // reset while in RD_WAIT
        cmd_valid = 1'b1;
        cmd_wr = 1'b0;
        cmd_addr = 12'h0AB;
        en_q.push_back('{cyc + 1, 1'b0, 12'h0AB, 16'h0});
        busy_lo = cyc + 1;
        busy_hi = cyc + 1000;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        chk_en = 1'b0;
        en_q.delete();
        rsp_q.delete();
        busy_lo = 1;
        busy_hi = 0;
        #1;
        check("rst_async_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        en_count = 0;
        rsp_count = 0;
        chk_en = 1'b1;
        idle(4, 1'b1);
        check("rst_en_cnt", en_count, 0);
        check("rst_rsp_cnt", rsp_count, 0);
        check("rst_ready", cmd_ready, 1'b1);
        idle(2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
